// File: rtl/sram_1r1w_masked_queue.sv
// sram_1r1w_masked_queue: single-clock 1R1W SRAM model with lane-masked writes, write-first bypass, zeroing sweep and a 2-entry read response queue
//   clock_i/reset_i                 clock, asynchronous active-high reset
//   wr_valid_i/wr_ready_o           write handshake; wr_addr_i, wr_data_i, wr_mask_i (1 bit per lane)
//   rd_req_valid_i/rd_req_ready_o   read request handshake; rd_addr_i
//   rd_resp_valid_o/rd_resp_ready_i response handshake; rd_data_o, rd_err_o (address out of range)
//   init_done_o                     high once every word has been zeroed after reset
module sram_1r1w_masked_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 25,
    parameter int MASK_GRAN = 8,
    localparam int NLANES = WIDTH / MASK_GRAN,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [NLANES-1:0] wr_mask_i,
    input  logic              rd_req_valid_i,
    output logic              rd_req_ready_o,
    input  logic [AW-1:0]     rd_addr_i,
    output logic              rd_resp_valid_o,
    input  logic              rd_resp_ready_i,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic              rd_err_o,
    output logic              init_done_o
);
    typedef enum logic {S_INIT, S_RUN} state_t;
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    state_t            state_q, state_d;
    logic [AW-1:0]     init_cnt_q, init_cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  q_data_q [2];
    logic [WIDTH-1:0]  q_data_d [2];
    logic              q_err_q [2];
    logic              q_err_d [2];
    logic [1:0]        count_q, count_d, base;
    logic              run, wr_fire, wr_in, rd_in, push, pop, bypass;
    logic [AW-1:0]     rd_idx;
    logic [WIDTH-1:0]  lane_bits, old_word, rd_word, wr_word;
    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        assign lane_bits[g*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{wr_mask_i[g]}};
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end
    always_comb begin
        state_d    = (state_q == S_INIT && init_cnt_q == LAST) ? S_RUN : state_q;
        init_cnt_d = (state_q == S_INIT) ? init_cnt_q + AW'(1) : init_cnt_q;
    end
    always_comb begin
        run            = (state_q == S_RUN);
        init_done_o    = run;
        wr_ready_o     = run;
        rd_req_ready_o = run & ((count_q < 2'd2) | rd_resp_ready_i);
    end
    always_comb begin
        wr_fire  = wr_valid_i & wr_ready_o;
        wr_in    = {1'b0, wr_addr_i} < DEPTH_W;
        rd_in    = {1'b0, rd_addr_i} < DEPTH_W;
        rd_idx   = rd_in ? rd_addr_i : '0;
        old_word = mem_q[rd_idx];
        // write-first: a same-cycle write to the read address is visible in the returned word
        bypass   = wr_fire & wr_in & (wr_addr_i == rd_addr_i);
        rd_word  = !rd_in ? '0 : bypass ? (old_word & ~lane_bits) | (wr_data_i & lane_bits) : old_word;
        wr_word  = (mem_q[wr_in ? wr_addr_i : '0] & ~lane_bits) | (wr_data_i & lane_bits);
    end
    always_ff @(posedge clock_i) begin
        if (state_q == S_INIT)
            mem_q[init_cnt_q] <= '0;
        else if (wr_fire && wr_in)
            mem_q[wr_addr_i] <= wr_word;
    end
    // entry 0 is always the head; a push lands in the first slot free after any pop
    always_comb begin
        pop         = (count_q != 2'd0) & rd_resp_ready_i;
        push        = rd_req_valid_i & rd_req_ready_o;
        base        = count_q - {1'b0, pop};
        q_data_d[0] = (push && base == 2'd0) ? rd_word : pop ? q_data_q[1] : q_data_q[0];
        q_err_d[0]  = (push && base == 2'd0) ? !rd_in : pop ? q_err_q[1] : q_err_q[0];
        q_data_d[1] = (push && base != 2'd0) ? rd_word : q_data_q[1];
        q_err_d[1]  = (push && base != 2'd0) ? !rd_in : q_err_q[1];
        count_d     = base + {1'b0, push};
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q     <= '0;
            q_data_q[0] <= '0;
            q_data_q[1] <= '0;
            q_err_q[0]  <= 1'b0;
            q_err_q[1]  <= 1'b0;
        end else begin
            count_q     <= count_d;
            q_data_q[0] <= q_data_d[0];
            q_data_q[1] <= q_data_d[1];
            q_err_q[0]  <= q_err_d[0];
            q_err_q[1]  <= q_err_d[1];
        end
    end
    always_comb begin
        rd_resp_valid_o = (count_q != 2'd0);
        rd_data_o       = rd_resp_valid_o ? q_data_q[0] : '0;
        rd_err_o        = rd_resp_valid_o & q_err_q[0];
    end
endmodule

// File: tb/tb_sram_1r1w_masked_queue.sv
// tb_sram_1r1w_masked_queue: scoreboard bench for sram_1r1w_masked_queue
module tb_sram_1r1w_masked_queue;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0, wr_ready;
    logic [4:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [7:0]  wr_mask = '0;
    logic        rd_req_valid = 1'b0, rd_req_ready;
    logic [4:0]  rd_addr = '0;
    logic        rd_resp_valid, rd_resp_ready = 1'b0;
    logic [63:0] rd_data;
    logic        rd_err, init_done;
    int          n_cmp = 0, n_err = 0;
    logic [63:0] model [25];
    logic [64:0] exp_q [$];
    logic [64:0] got_q [$];
    logic        last_req_ready, last_resp_valid;
    logic [63:0] last_resp_data;

    sram_1r1w_masked_queue dut (
        .clock_i(clock), .reset_i(reset),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_mask_i(wr_mask),
        .rd_req_valid_i(rd_req_valid), .rd_req_ready_o(rd_req_ready), .rd_addr_i(rd_addr),
        .rd_resp_valid_o(rd_resp_valid), .rd_resp_ready_i(rd_resp_ready),
        .rd_data_o(rd_data), .rd_err_o(rd_err), .init_done_o(init_done)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) o[i*8 +: 8] = d[i*8 +: 8];
        return o;
    endfunction

    // one clock of stimulus; records accepted reads (expected) and popped responses (observed)
    task automatic step(input logic wv, input logic [4:0] wa, input logic [63:0] wd, input logic [7:0] wm,
                        input logic rv, input logic [4:0] ra, input logic rr);
        logic wacc, racc;
        logic [63:0] e;
        @(negedge clock);
        wr_valid = wv; wr_addr = wa; wr_data = wd; wr_mask = wm;
        rd_req_valid = rv; rd_addr = ra; rd_resp_ready = rr;
        #1;
        last_req_ready = rd_req_ready;
        last_resp_valid = rd_resp_valid;
        last_resp_data = rd_data;
        wacc = wv & wr_ready;
        racc = rv & rd_req_ready;
        if (racc) begin
            e = (ra < 5'd25) ? model[ra] : 64'h0;
            if (wacc && wa == ra && ra < 5'd25) e = merge(e, wd, wm);
            exp_q.push_back({ra >= 5'd25, e});
        end
        if (rd_resp_valid && rr) got_q.push_back({rd_err, rd_data});
        @(posedge clock);
        if (wacc && wa < 5'd25) model[wa] = merge(model[wa], wd, wm);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (!init_done && n < 100) begin
            @(posedge clock); #1; n++;
        end
        n_cmp++;
        if (n != 25) begin
            n_err++;
            $display("FAIL %s init cycles got %0d want 25", name, n);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 25; i++) model[i] = '0;
        #3;
        n_cmp++;
        if ({wr_ready, rd_req_ready, rd_resp_valid, rd_err, init_done} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got %b want 00000", {wr_ready, rd_req_ready, rd_resp_valid, rd_err, init_done});
        end
        n_cmp++;
        if (rd_data !== 64'h0) begin n_err++; $display("FAIL reset_data got %h want 0", rd_data); end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        n_cmp++;
        if (rd_req_ready !== 1'b0 || wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_ready got %b%b want 00", wr_ready, rd_req_ready);
        end
        @(negedge clock);
        while (!init_done && 0) @(posedge clock);
        // one posedge already elapsed; count the rest
        begin
            int n = 1;
            while (!init_done && n < 100) begin
                @(posedge clock); #1; n++;
            end
            n_cmp++;
            if (n != 25) begin n_err++; $display("FAIL init_cycles got %0d want 25", n); end
        end
    endtask

    task automatic test_read_all;
        logic [64:0] e, g;
        for (int a = 0; a < 25; a++) step(0, 0, 0, 0, 1, 5'(a), 1);
        idle(3);
        n_cmp++;
        if (got_q.size() != 25) begin n_err++; $display("FAIL read_all_count got %0d want 25", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e || g !== 65'h0) begin n_err++; $display("FAIL read_all got %h want %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_masked_write;
        logic [64:0] g;
        step(1, 3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 1);
        step(1, 3, 64'h0, 8'h0F, 0, 0, 1);
        step(1, 4, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1, 3, 1);
        idle(2);
        n_cmp++;
        if (got_q.size() != 1) begin n_err++; $display("FAIL masked_count got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            n_cmp++;
            if (g !== {1'b0, 64'hFFFF_FFFF_0000_0000}) begin
                n_err++; $display("FAIL masked_write got %h want 0ffffffff00000000", g);
            end
        end
        step(0, 0, 0, 0, 1, 4, 1);
        idle(2);
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            n_cmp++;
            if (g !== 65'h0) begin n_err++; $display("FAIL zero_mask_write got %h want 0", g); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_bypass;
        logic [64:0] g;
        step(1, 7, 64'h1122_3344_5566_7788, 8'h01, 1, 7, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (got_q.size() != 1) begin n_err++; $display("FAIL bypass_latency got %0d entries want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            n_cmp++;
            if (g !== {1'b0, 64'h0000_0000_0000_0088}) begin
                n_err++; $display("FAIL bypass got %h want 00000000000000088", g);
            end
        end
        step(0, 0, 0, 0, 1, 7, 1);
        idle(2);
        while (exp_q.size() > 1 && got_q.size() > 0) void'(exp_q.pop_front());
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            n_cmp++;
            if (g !== exp_q[0]) begin n_err++; $display("FAIL bypass_commit got %h want %h", g, exp_q[0]); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [64:0] e, g;
        logic [63:0] a1 = 64'hA1A1_0000_0000_0001;
        step(1, 1, a1, 8'hFF, 0, 0, 1);
        step(1, 2, 64'hB2B2_0000_0000_0002, 8'hFF, 0, 0, 1);
        step(1, 3, 64'hC3C3_0000_0000_0003, 8'hFF, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 2, 0);
        step(0, 0, 0, 0, 1, 3, 0);
        n_cmp++;
        if (last_req_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready got %b want 0", last_req_ready); end
        n_cmp++;
        if (last_resp_valid !== 1'b1 || last_resp_data !== a1) begin
            n_err++; $display("FAIL stall_head got %b/%h want 1/%h", last_resp_valid, last_resp_data, a1);
        end
        step(0, 0, 0, 0, 1, 3, 0);
        n_cmp++;
        if (last_resp_data !== a1) begin n_err++; $display("FAIL stall_hold got %h want %h", last_resp_data, a1); end
        step(0, 0, 0, 0, 1, 3, 1);
        n_cmp++;
        if (last_req_ready !== 1'b1) begin n_err++; $display("FAIL full_push_pop_ready got %b want 1", last_req_ready); end
        idle(4);
        n_cmp++;
        if (got_q.size() != 3 || exp_q.size() != 3) begin
            n_err++; $display("FAIL stall_count got %0d want 3 (expected %0d)", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL stall_order got %h want %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_out_of_range;
        logic [64:0] e, g;
        step(0, 0, 0, 0, 1, 30, 1);
        idle(2);
        n_cmp++;
        if (got_q.size() != 1) begin n_err++; $display("FAIL oor_count got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            n_cmp++;
            if (g !== {1'b1, 64'h0}) begin n_err++; $display("FAIL oor_read got %h want 10000000000000000", g); end
        end
        exp_q.delete(); got_q.delete();
        step(1, 30, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 1);
        for (int a = 0; a < 25; a++) step(0, 0, 0, 0, 1, 5'(a), 1);
        idle(3);
        n_cmp++;
        if (got_q.size() != 25) begin n_err++; $display("FAIL oor_scan_count got %0d want 25", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL oor_write_side_effect got %h want %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid;
        logic [64:0] g;
        step(1, 5, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 0, 0, 1);
        step(0, 0, 0, 0, 1, 5, 0);
        step(0, 0, 0, 0, 1, 5, 0);
        @(negedge clock);
        #2 reset = 1'b1;
        wr_valid = 0; rd_req_valid = 0; rd_resp_ready = 1;
        #1;
        n_cmp++;
        if (rd_resp_valid !== 1'b0 || init_done !== 1'b0 || rd_data !== 64'h0) begin
            n_err++; $display("FAIL reset_mid got valid=%b done=%b data=%h want 0/0/0", rd_resp_valid, init_done, rd_data);
        end
        for (int i = 0; i < 25; i++) model[i] = '0;
        exp_q.delete(); got_q.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        wait_init("reset_mid");
        step(0, 0, 0, 0, 1, 5, 1);
        idle(2);
        n_cmp++;
        if (got_q.size() != 1) begin n_err++; $display("FAIL reset_mid_count got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            n_cmp++;
            if (g !== 65'h0) begin n_err++; $display("FAIL reset_mid_zero got %h want 0", g); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        test_reset;
        test_read_all;
        test_masked_write;
        test_bypass;
        test_back_to_back;
        test_out_of_range;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
